uart_cmd_dispatcher: RTL and testbench

Parametrised command dispatcher between the UART receiver and NCH transfer engines (read, write, and later additions). Each received byte is matched against a per-channel opcode table. On a match, the block raises that channel's start request and holds it until the channel reports done. It adds a per-command timeout watchdog, coded error reporting, a sticky overrun flag and an explicit error clear, none of which the two-channel predecessor had.

---
 rtl/uart_cmd_pkg.sv | 22 ++
 rtl/cmd_opcode_decoder.sv | 27 ++
 rtl/uart_cmd_dispatcher.sv | 139 +++++++++++++
 tb/tb_uart_cmd_dispatcher.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and codes for the UART command dispatcher.
// Pure declarations, no logic and therefore no latency.
// No flow control here; consumers own all handshaking.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // err_code values
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OPC  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  // status LED codes
  localparam logic [1:0] LED_IDLE = 2'd0;
  localparam logic [1:0] LED_RUN  = 2'd1;
  localparam logic [1:0] LED_ERR  = 2'd2;

endpackage

// File: rtl/cmd_opcode_decoder.sv
// Matches a command byte against a packed per-channel opcode table.
// Purely combinational, zero latency.
// No backpressure; result is valid whenever cmd is.
module cmd_opcode_decoder #(
  parameter int DW = 8,
  parameter int NCH = 2,
  parameter int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [DW-1:0]     cmd,
  input  logic [NCH*DW-1:0] opcodes,
  output logic              hit,
  output logic [CW-1:0]     idx
);

  // Scan from the top down so the lowest matching channel is the last writer.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (opcodes[i*DW +: DW] == cmd) begin
        hit = 1'b1;
        idx = CW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_dispatcher.sv
// Dispatches UART command bytes to one of NCH engines, with watchdog and error reporting.
// Latency 1: start/busy/status/err update on the edge after rx_valid or done is sampled.
// No backpressure: commands arriving while a channel runs are dropped and flag overrun.
module uart_cmd_dispatcher
  import uart_cmd_pkg::*;
#(
  parameter int DW = 8,
  parameter int NCH = 2,
  parameter logic [NCH*DW-1:0] OPCODES = {8'h0F, 8'hF0},
  parameter int TIMEOUT = 1000000,
  // derived widths, not meant to be overridden
  parameter int CW = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int TW = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_valid,
  input  logic [DW-1:0]  rx_data,
  input  logic [NCH-1:0] done,
  input  logic           clr_err,
  output logic [NCH-1:0] start,
  output logic           busy,
  output logic [CW-1:0]  ch_idx,
  output logic           err,
  output logic [1:0]     err_code,
  output logic           overrun,
  output logic [1:0]     status
);

  // Watchdog fires on the RUN cycle where the counter reads TIMEOUT-1,
  // so start stays high for exactly TIMEOUT cycles. TIMEOUT=0 disables it.
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] WD_LAST = (TIMEOUT != 0) ? TW'(TIMEOUT - 1) : '0;

  state_t        state;
  logic [TW-1:0] wd;
  logic          hit;
  logic [CW-1:0] hit_idx;

  cmd_opcode_decoder #(
    .DW  (DW),
    .NCH (NCH),
    .CW  (CW)
  ) u_dec (
    .cmd     (rx_data),
    .opcodes (OPCODES),
    .hit     (hit),
    .idx     (hit_idx)
  );

  // Single FSM register block: state, watchdog, and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wd       <= '0;
      start    <= '0;
      busy     <= 1'b0;
      ch_idx   <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      overrun  <= 1'b0;
      status   <= LED_IDLE;
    end else begin
      // clr_err drops the sticky overrun in every state; a new overrun in RUN below wins.
      if (clr_err) overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (hit) begin
              state    <= ST_RUN;
              start    <= NCH'(1) << hit_idx;
              busy     <= 1'b1;
              ch_idx   <= hit_idx;
              status   <= LED_RUN;
              wd       <= '0;
            end else begin
              state    <= ST_ERR;
              err      <= 1'b1;
              err_code <= ERR_OPC;
              status   <= LED_ERR;
            end
          end
        end

        ST_RUN: begin
          if (rx_valid) overrun <= 1'b1;
          // done on the active channel beats a coincident timeout
          if (done[ch_idx]) begin
            state  <= ST_IDLE;
            start  <= '0;
            busy   <= 1'b0;
            status <= LED_IDLE;
          end else if (WD_EN && (wd == WD_LAST)) begin
            state    <= ST_ERR;
            start    <= '0;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TMO;
            status   <= LED_ERR;
          end else if (wd != {TW{1'b1}}) begin
            wd <= wd + 1'b1;
          end
        end

        ST_ERR: begin
          // a valid command outranks clr_err and restarts directly
          if (rx_valid && hit) begin
            state    <= ST_RUN;
            start    <= NCH'(1) << hit_idx;
            busy     <= 1'b1;
            ch_idx   <= hit_idx;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            status   <= LED_RUN;
            wd       <= '0;
          end else if (rx_valid) begin
            err_code <= ERR_OPC;
          end else if (clr_err) begin
            state    <= ST_IDLE;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            status   <= LED_IDLE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          start    <= '0;
          busy     <= 1'b0;
          err      <= 1'b0;
          err_code <= ERR_NONE;
          status   <= LED_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Directed bench for uart_cmd_dispatcher: default, short-timeout and 4-channel instances.
// Expected values are hand-derived constants.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_uart_cmd_dispatcher;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // default instance
  logic       d_rx_valid, d_clr_err;
  logic [7:0] d_rx_data;
  logic [1:0] d_done, d_start;
  logic       d_busy, d_ch_idx, d_err, d_overrun;
  logic [1:0] d_err_code, d_status;

  // TIMEOUT=8 instance
  logic       t_rx_valid, t_clr_err;
  logic [7:0] t_rx_data;
  logic [1:0] t_done, t_start;
  logic       t_busy, t_ch_idx, t_err, t_overrun;
  logic [1:0] t_err_code, t_status;

  // NCH=4, watchdog disabled
  logic       q_rx_valid, q_clr_err;
  logic [7:0] q_rx_data;
  logic [3:0] q_done, q_start;
  logic       q_busy, q_err, q_overrun;
  logic [1:0] q_ch_idx, q_err_code, q_status;

  uart_cmd_dispatcher u_def (
    .clk(clk), .rst(rst), .rx_valid(d_rx_valid), .rx_data(d_rx_data), .done(d_done),
    .clr_err(d_clr_err), .start(d_start), .busy(d_busy), .ch_idx(d_ch_idx), .err(d_err),
    .err_code(d_err_code), .overrun(d_overrun), .status(d_status)
  );

  uart_cmd_dispatcher #(.TIMEOUT(8)) u_tmo (
    .clk(clk), .rst(rst), .rx_valid(t_rx_valid), .rx_data(t_rx_data), .done(t_done),
    .clr_err(t_clr_err), .start(t_start), .busy(t_busy), .ch_idx(t_ch_idx), .err(t_err),
    .err_code(t_err_code), .overrun(t_overrun), .status(t_status)
  );

  uart_cmd_dispatcher #(.NCH(4), .OPCODES({8'hA0, 8'hA0, 8'h0F, 8'hF0}), .TIMEOUT(0)) u_n4 (
    .clk(clk), .rst(rst), .rx_valid(q_rx_valid), .rx_data(q_rx_data), .done(q_done),
    .clr_err(q_clr_err), .start(q_start), .busy(q_busy), .ch_idx(q_ch_idx), .err(q_err),
    .err_code(q_err_code), .overrun(q_overrun), .status(q_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    d_rx_valid = 0; d_rx_data = 0; d_done = 0; d_clr_err = 0;
    t_rx_valid = 0; t_rx_data = 0; t_done = 0; t_clr_err = 0;
    q_rx_valid = 0; q_rx_data = 0; q_done = 0; q_clr_err = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_start", d_start, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_ch_idx", d_ch_idx, 0);
    chk("rst_err", {d_err, d_err_code}, 0);
    chk("rst_overrun", d_overrun, 0);
    chk("rst_status", d_status, 0);

    // F0 -> ch0, done[0] five cycles later
    d_rx_valid = 1; d_rx_data = 8'hF0; tick(); d_rx_valid = 0;
    chk("f0_start", d_start, 2'b01);
    chk("f0_ch_idx", d_ch_idx, 0);
    chk("f0_status", d_status, 1);
    chk("f0_busy", d_busy, 1);
    repeat (4) tick();
    d_done = 2'b01; tick(); d_done = 0;
    chk("f0_done_start", d_start, 0);
    chk("f0_done_busy", d_busy, 0);
    chk("f0_done_status", d_status, 0);

    // 0F -> ch1, wrong-channel done ignored
    d_rx_valid = 1; d_rx_data = 8'h0F; tick(); d_rx_valid = 0;
    chk("0f_start", d_start, 2'b10);
    chk("0f_ch_idx", d_ch_idx, 1);
    d_done = 2'b01; tick(); d_done = 0;
    chk("0f_wrong_done", d_start, 2'b10);
    tick();
    chk("0f_hold", d_start, 2'b10);
    d_done = 2'b10; tick(); d_done = 0;
    chk("0f_done_start", d_start, 0);
    chk("0f_done_busy", d_busy, 0);

    // unknown opcode, then recover with F0
    d_rx_valid = 1; d_rx_data = 8'h55; tick(); d_rx_valid = 0;
    chk("unk_err", d_err, 1);
    chk("unk_code", d_err_code, 1);
    chk("unk_status", d_status, 2);
    chk("unk_start", d_start, 0);
    d_rx_valid = 1; d_rx_data = 8'hF0; tick(); d_rx_valid = 0;
    chk("rec_start", d_start, 2'b01);
    chk("rec_err", {d_err, d_err_code}, 0);
    chk("rec_status", d_status, 1);
    d_done = 2'b01; tick(); d_done = 0;

    // overrun while running
    d_rx_valid = 1; d_rx_data = 8'hF0; tick();
    tick(); d_rx_valid = 0;
    chk("ovr_flag", d_overrun, 1);
    chk("ovr_start", d_start, 2'b01);
    d_done = 2'b01; tick(); d_done = 0;
    chk("ovr_sticky", d_overrun, 1);
    chk("ovr_idle", d_status, 0);
    d_clr_err = 1; tick(); d_clr_err = 0;
    chk("ovr_clear", d_overrun, 0);

    // ERR with clr_err and valid 0F together -> RUN on ch1
    d_rx_valid = 1; d_rx_data = 8'h55; tick();
    d_rx_data = 8'h0F; d_clr_err = 1; tick(); d_rx_valid = 0; d_clr_err = 0;
    chk("errclr_start", d_start, 2'b10);
    chk("errclr_ch_idx", d_ch_idx, 1);
    chk("errclr_err", d_err, 0);
    chk("errclr_status", d_status, 1);
    d_done = 2'b10; tick(); d_done = 0;

    // timeout: start high for exactly 8 cycles
    t_rx_valid = 1; t_rx_data = 8'hF0; tick(); t_rx_valid = 0;
    n = 0;
    while (t_start[0] && n < 20) begin
      n++;
      tick();
    end
    chk("tmo_high_cycles", n, 8);
    chk("tmo_code", t_err_code, 2);
    chk("tmo_err", t_err, 1);
    chk("tmo_status", t_status, 2);
    chk("tmo_busy", t_busy, 0);
    t_rx_valid = 1; t_rx_data = 8'h55; tick(); t_rx_valid = 0;
    chk("tmo_overwrite", t_err_code, 1);
    t_clr_err = 1; tick(); t_clr_err = 0;
    chk("tmo_clr", {t_err, t_err_code, t_status}, 0);

    // done on the final watchdog cycle wins
    t_rx_valid = 1; t_rx_data = 8'hF0; tick(); t_rx_valid = 0;
    repeat (7) tick();
    chk("tmo_last_still_run", t_start, 2'b01);
    t_done = 2'b01; tick(); t_done = 0;
    chk("tmo_race_start", t_start, 0);
    chk("tmo_race_err", {t_err, t_err_code}, 0);
    chk("tmo_race_status", t_status, 0);

    // NCH=4: lowest matching channel, no watchdog
    q_rx_valid = 1; q_rx_data = 8'hA0; tick(); q_rx_valid = 0;
    chk("n4_ch_idx", q_ch_idx, 2);
    chk("n4_start", q_start, 4'b0100);
    repeat (30) tick();
    chk("n4_no_tmo", {q_start, q_err}, {4'b0100, 1'b0});
    q_rx_valid = 1; q_rx_data = 8'hF0; tick(); q_rx_valid = 0;
    chk("n4_ovr", q_overrun, 1);

    // reset mid-RUN
    rst = 1; tick();
    chk("mid_rst_start", q_start, 0);
    chk("mid_rst_busy", q_busy, 0);
    chk("mid_rst_ch_idx", q_ch_idx, 0);
    chk("mid_rst_ovr", q_overrun, 0);
    chk("mid_rst_status", {q_err, q_err_code, q_status}, 0);
    rst = 0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
